// File: rtl/uc_multiciclo_if.sv
// Control bundle between the multi-cycle control unit and the fd datapath.
// The control unit is the master; the datapath (or a bench) is the slave.
interface uc_multiciclo_if #(
   parameter int CNT_BITS = 32
);
   logic [6:0]          opcode;
   logic [3:0]          alu_flags;
   logic                d_mem_ready;
   logic                d_mem_we;
   logic                rf_we;
   logic                pc_we;
   logic [3:0]          alu_cmd;
   logic                alu_src;
   logic                pc_src;
   logic                rf_src;
   logic                fault;
   logic [CNT_BITS-1:0] retired;
   logic [3:0]          state_dbg;

   modport master (
      input  opcode, alu_flags, d_mem_ready,
      output d_mem_we, rf_we, pc_we, alu_cmd, alu_src, pc_src, rf_src,
             fault, retired, state_dbg
   );

   modport slave (
      output opcode, alu_flags, d_mem_ready,
      input  d_mem_we, rf_we, pc_we, alu_cmd, alu_src, pc_src, rf_src,
             fault, retired, state_dbg
   );
endinterface

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit for the 64-bit RISC-V datapath: sequences each
// instruction through fetch/decode/exec/mem/writeback and drives fd's strobes.
module uc_multiciclo #(
   parameter int CNT_BITS     = 32,
   parameter int MEM_WAIT_MAX = 15
) (
   input logic              clk,
   input logic              rst_n,
   uc_multiciclo_if.master  bus
);

   localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC   = 4'd2,
      S_MEM_RD = 4'd3,
      S_MEM_WR = 4'd4,
      S_WB     = 4'd5,
      S_BRANCH = 4'd6,
      S_FAULT  = 4'd7
   } state_t;

   typedef enum logic [2:0] {
      K_R, K_I, K_LD, K_SD, K_BEQ, K_LUI, K_JAL, K_BAD
   } kind_t;

   typedef struct packed {
      logic       rf_we;
      logic       pc_we;
      logic       d_mem_we;
      logic       rf_src;
      logic       pc_src;
      logic       alu_src;
      logic [3:0] alu_cmd;
   } ctrl_t;

   function automatic kind_t classify(input logic [6:0] op);
      kind_t k;
      case (op)
         7'b0110011: k = K_R;
         7'b0010011: k = K_I;
         7'b0000011: k = K_LD;
         7'b0100011: k = K_SD;
         7'b1100011: k = K_BEQ;
         7'b0110111: k = K_LUI;
         7'b1101111: k = K_JAL;
         default:    k = K_BAD;
      endcase
      return k;
   endfunction

   function automatic logic [3:0] alu_cmd_of(input kind_t k);
      logic [3:0] cmd;
      case (k)
         K_I, K_LD: cmd = 4'd1;
         K_SD:      cmd = 4'd2;
         K_BEQ:     cmd = 4'd3;
         K_LUI:     cmd = 4'd4;
         K_JAL:     cmd = 4'd5;
         default:   cmd = 4'd0;
      endcase
      return cmd;
   endfunction

   function automatic logic uses_imm(input kind_t k);
      return !(k == K_R || k == K_BEQ);
   endfunction

   // Control word for the state being entered; alu_cmd/alu_src stay put
   // through MEM_* and WB so the address and write-back data remain valid.
   function automatic ctrl_t moore_out(input state_t s, input kind_t k, input logic br);
      ctrl_t c;
      c = '0;
      case (s)
         S_EXEC: begin
            c.alu_cmd = alu_cmd_of(k);
            c.alu_src = uses_imm(k);
         end
         S_MEM_RD: begin
            c.rf_src  = 1'b1;
            c.alu_cmd = 4'd1;
            c.alu_src = 1'b1;
         end
         S_MEM_WR: begin
            c.d_mem_we = 1'b1;
            c.alu_cmd  = 4'd2;
            c.alu_src  = 1'b1;
         end
         S_WB: begin
            c.rf_we   = 1'b1;
            c.pc_we   = 1'b1;
            c.rf_src  = (k == K_LD);
            c.pc_src  = (k == K_JAL);
            c.alu_cmd = alu_cmd_of(k);
            c.alu_src = uses_imm(k);
         end
         S_BRANCH: begin
            c.alu_cmd = 4'd3;
            c.pc_we   = 1'b1;
            c.pc_src  = br;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t              state;
   logic [6:0]          op_q;
   logic                br_q;
   ctrl_t               ctrl_q;
   logic                fault_q;
   logic [CNT_BITS-1:0] retired_q;
   logic [WAIT_W-1:0]   wait_cnt;
   kind_t               kind_q;
   kind_t               kind_in;
   logic                mem_timeout;
   logic                unused_flags;

   assign kind_q       = classify(op_q);
   assign kind_in      = classify(bus.opcode);
   assign mem_timeout  = (32'(wait_cnt) + 1 == MEM_WAIT_MAX);
   assign unused_flags = ^bus.alu_flags[3:1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_FETCH;
         op_q      <= '0;
         br_q      <= 1'b0;
         ctrl_q    <= '0;
         fault_q   <= 1'b0;
         retired_q <= '0;
         wait_cnt  <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               state  <= S_DECODE;
               ctrl_q <= '0;
            end
            S_DECODE: begin
               op_q <= bus.opcode;
               if (kind_in == K_BAD) begin
                  state   <= S_FAULT;
                  fault_q <= 1'b1;
                  ctrl_q  <= '0;
               end else begin
                  state  <= S_EXEC;
                  ctrl_q <= moore_out(S_EXEC, kind_in, br_q);
               end
            end
            S_EXEC: begin
               br_q     <= bus.alu_flags[0];
               wait_cnt <= '0;
               case (kind_q)
                  K_LD: begin
                     state  <= S_MEM_RD;
                     ctrl_q <= moore_out(S_MEM_RD, kind_q, bus.alu_flags[0]);
                  end
                  K_SD: begin
                     state  <= S_MEM_WR;
                     ctrl_q <= moore_out(S_MEM_WR, kind_q, bus.alu_flags[0]);
                  end
                  K_BEQ: begin
                     state  <= S_BRANCH;
                     ctrl_q <= moore_out(S_BRANCH, kind_q, bus.alu_flags[0]);
                  end
                  default: begin
                     state  <= S_WB;
                     ctrl_q <= moore_out(S_WB, kind_q, bus.alu_flags[0]);
                  end
               endcase
            end
            S_MEM_RD: begin
               if (bus.d_mem_ready) begin
                  state  <= S_WB;
                  ctrl_q <= moore_out(S_WB, kind_q, br_q);
               end else if (mem_timeout) begin
                  state   <= S_FAULT;
                  fault_q <= 1'b1;
                  ctrl_q  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_MEM_WR: begin
               if (bus.d_mem_ready) begin
                  state     <= S_FETCH;
                  ctrl_q    <= '0;
                  retired_q <= retired_q + 1'b1;
               end else if (mem_timeout) begin
                  state   <= S_FAULT;
                  fault_q <= 1'b1;
                  ctrl_q  <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_WB, S_BRANCH: begin
               state     <= S_FETCH;
               ctrl_q    <= '0;
               retired_q <= retired_q + 1'b1;
            end
            S_FAULT: begin
               ctrl_q  <= '0;
               fault_q <= 1'b1;
            end
            default: begin
               state   <= S_FAULT;
               fault_q <= 1'b1;
               ctrl_q  <= '0;
            end
         endcase
      end
   end

   // A store retires on the same edge memory reports ready, so its PC load
   // has to be qualified by ready inside MEM_WR rather than registered.
   assign bus.pc_we     = ctrl_q.pc_we | ((state == S_MEM_WR) && bus.d_mem_ready);
   assign bus.rf_we     = ctrl_q.rf_we;
   assign bus.d_mem_we  = ctrl_q.d_mem_we;
   assign bus.rf_src    = ctrl_q.rf_src;
   assign bus.pc_src    = ctrl_q.pc_src;
   assign bus.alu_src   = ctrl_q.alu_src;
   assign bus.alu_cmd   = ctrl_q.alu_cmd;
   assign bus.fault     = fault_q;
   assign bus.retired   = retired_q;
   assign bus.state_dbg = state;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Bench for uc_multiciclo: per-instruction expected state traces and control
// words built from the opcode rules, with randomized opcodes, flags and waits.
module tb_uc_multiciclo;

   localparam int CNT_BITS = 4;
   localparam int MAX_WAIT = 3;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [2:0] {T_R, T_I, T_LD, T_SD, T_BEQ, T_LUI, T_JAL, T_BAD} cls_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   model_ret = 0;

   uc_multiciclo_if #(.CNT_BITS(CNT_BITS)) bus ();

   uc_multiciclo #(.CNT_BITS(CNT_BITS), .MEM_WAIT_MAX(MAX_WAIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic cls_t cls_of(input logic [6:0] op);
      case (op)
         OP_R:    return T_R;
         OP_I:    return T_I;
         OP_LD:   return T_LD;
         OP_SD:   return T_SD;
         OP_BEQ:  return T_BEQ;
         OP_LUI:  return T_LUI;
         OP_JAL:  return T_JAL;
         default: return T_BAD;
      endcase
   endfunction

   function automatic logic [3:0] cmd_of(input cls_t c);
      case (c)
         T_I, T_LD: return 4'd1;
         T_SD:      return 4'd2;
         T_BEQ:     return 4'd3;
         T_LUI:     return 4'd4;
         T_JAL:     return 4'd5;
         default:   return 4'd0;
      endcase
   endfunction

   // {rf_we, pc_we, d_mem_we, rf_src, pc_src, alu_src, alu_cmd}
   function automatic logic [9:0] exp_ctrl(input int st, input cls_t c, input logic br, input logic rdy);
      logic imm;
      imm = !(c == T_R || c == T_BEQ);
      case (st)
         2:       return {5'b00000, imm, cmd_of(c)};
         3:       return {3'b000, 1'b1, 1'b0, 1'b1, 4'd1};
         4:       return {1'b0, rdy, 1'b1, 2'b00, 1'b1, 4'd2};
         5:       return {2'b11, 1'b0, c == T_LD, c == T_JAL, imm, cmd_of(c)};
         6:       return {1'b0, 1'b1, 2'b00, br, 1'b0, 4'd3};
         default: return 10'd0;
      endcase
   endfunction

   function automatic logic [9:0] obs_ctrl();
      return {bus.rf_we, bus.pc_we, bus.d_mem_we, bus.rf_src, bus.pc_src,
              bus.alu_src, bus.alu_cmd};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_state",   32'(bus.state_dbg), 32'd0);
      check("rst_ctrl",    32'(obs_ctrl()),    32'd0);
      check("rst_fault",   32'(bus.fault),     32'd0);
      check("rst_retired", 32'(bus.retired),   32'd0);
      model_ret = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // zero < 0 leaves the EXEC zero flag random; abort_at >= 0 pulses reset
   // in the middle of that trace cycle.
   task automatic run_instr(input logic [6:0] op, input int waits, input int zero, input int abort_at);
      cls_t c;
      int   seq[$];
      int   k;
      int   st;
      int   ms;
      logic br;
      logic rdy;
      logic ends_in_fault;
      c  = cls_of(op);
      k  = 0;
      br = 1'b0;
      ends_in_fault = 1'b0;
      seq.push_back(0);
      seq.push_back(1);
      if (c == T_BAD) begin
         repeat (4) seq.push_back(7);
         ends_in_fault = 1'b1;
      end else begin
         seq.push_back(2);
         if (c == T_LD || c == T_SD) begin
            ms = (c == T_LD) ? 3 : 4;
            if (waits < MAX_WAIT) begin
               repeat (waits + 1) seq.push_back(ms);
               if (c == T_LD) seq.push_back(5);
            end else begin
               repeat (MAX_WAIT) seq.push_back(ms);
               repeat (3) seq.push_back(7);
               ends_in_fault = 1'b1;
            end
         end else begin
            seq.push_back(c == T_BEQ ? 6 : 5);
         end
      end
      foreach (seq[i]) begin
         st = seq[i];
         bus.opcode    = (st == 1) ? op : 7'($urandom);
         bus.alu_flags = 4'($urandom);
         if (st == 2 && zero >= 0) bus.alu_flags[0] = zero[0];
         if (st == 2) br = bus.alu_flags[0];
         if (st == 3 || st == 4) begin
            rdy = (k == waits);
            k++;
         end else begin
            rdy = 1'($urandom);
         end
         bus.d_mem_ready = rdy;
         #1;
         check($sformatf("state op=%b cyc=%0d", op, i), 32'(bus.state_dbg), 32'(st));
         check($sformatf("ctrl op=%b cyc=%0d", op, i), 32'(obs_ctrl()), 32'(exp_ctrl(st, c, br, rdy)));
         check($sformatf("fault op=%b cyc=%0d", op, i), 32'(bus.fault), 32'(st == 7));
         check($sformatf("retired op=%b cyc=%0d", op, i), 32'(bus.retired), 32'(model_ret));
         if (i == abort_at) begin
            #1;
            do_reset();
            return;
         end
         if (st == 5 || st == 6 || (st == 4 && rdy)) model_ret = (model_ret + 1) % (1 << CNT_BITS);
         @(negedge clk);
      end
      if (ends_in_fault) do_reset();
   endtask

   initial begin
      logic [6:0] ops[8];
      logic [6:0] op;
      bus.opcode      = '0;
      bus.alu_flags   = '0;
      bus.d_mem_ready = 1'b0;
      ops = '{OP_R, OP_I, OP_LD, OP_SD, OP_BEQ, OP_LUI, OP_JAL, 7'b1111111};
      #2;
      do_reset();

      run_instr(OP_R,   0, -1, -1);
      run_instr(OP_LD,  2, -1, -1);
      run_instr(OP_BEQ, 0,  1, -1);
      run_instr(OP_BEQ, 0,  0, -1);
      run_instr(OP_I,   0, -1, -1);
      run_instr(OP_LUI, 0, -1, -1);
      run_instr(OP_JAL, 0, -1, -1);
      run_instr(OP_SD,  0, -1, -1);
      run_instr(OP_SD,  1, -1, -1);
      run_instr(OP_SD,  9, -1, -1);
      run_instr(OP_LD,  9, -1, -1);
      run_instr(7'b1111111, 0, -1, -1);
      repeat (17) run_instr(OP_R, 0, -1, -1);
      run_instr(OP_SD,  9, -1, 4);

      for (int n = 0; n < 80; n++) begin
         op = ops[$urandom_range(0, 7)];
         if (op == 7'b1111111) op = 7'($urandom);
         run_instr(op, $urandom_range(0, 4), -1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
